execute_iter: RTL and testbench

//  Next-generation LC-3b execute stage with a parametrised datapath width.

---
 rtl/execute_iter.sv | 204 ++++++++++++++++++++
 tb/tb_execute_iter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_iter.sv
// LC-3b execute stage: single-cycle ALU ops plus iterative shift-add MUL and restoring DIV.
// Optional remainder output enabled by defining EXECUTE_ITER_REM_EN.
module execute_iter #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       dr_in,
  input  logic             load_reg_in,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_dr,
  output logic             out_load_reg,
  output logic [2:0]       out_cc,
  output logic             div_by_zero
`ifdef EXECUTE_ITER_REM_EN
  ,
  output logic [WIDTH-1:0] out_rem
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_DIV  = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_x, r_y, w_x_nx, w_y_nx;
  logic [WIDTH:0]   r_z, w_z_nx;
  logic             r_is_div;
  logic [2:0]       r_pend_dr;
  logic             r_pend_load;
  logic             r_out_valid, r_out_load, r_out_dbz;
  logic [WIDTH-1:0] r_out_result, w_single;
  logic [2:0]       r_out_dr;
  logic [SW-1:0]    w_shamt;
  logic             w_in_ready, w_fire, w_div0, w_is_iter;

  assign w_in_ready = (r_state == S_IDLE) && !mem_stall;
  assign w_fire     = valid_in && w_in_ready && !flush;
  assign w_div0     = (op_in == OP_DIV) && (b == {WIDTH{1'b0}});
  assign w_is_iter  = (op_in == OP_MUL) || ((op_in == OP_DIV) && !w_div0);
  assign w_shamt    = b[SW-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // FSM next state; flush always returns to IDLE
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_fire && w_is_iter) w_state_nx = S_RUN;  else w_state_nx = S_IDLE;
      S_RUN:   if (r_cnt == CW'(1))     w_state_nx = S_DONE; else w_state_nx = S_RUN;
      S_DONE:  if (!mem_stall)          w_state_nx = S_IDLE; else w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
    else       w_state_nx = w_state_nx;
  end

  // Single-cycle ALU result (DIV here only covers the divide-by-zero case)
  always_comb begin
    w_single = {WIDTH{1'b0}};
    case (op_in)
      OP_ADD:  w_single = a + b;
      OP_AND:  w_single = a & b;
      OP_NOT:  w_single = ~a;
      OP_PASS: w_single = b;
      OP_SLL:  w_single = a << w_shamt;
      OP_SRA:  w_single = $unsigned($signed(a) >>> w_shamt);
      OP_DIV:  w_single = {WIDTH{1'b1}};
      default: w_single = {WIDTH{1'b0}};
    endcase
  end

  // One iteration: MUL uses x=multiplicand, y=multiplier, z=accumulator;
  // DIV uses x=divisor, y=dividend shifting into quotient, z=partial remainder.
  always_comb begin
    w_x_nx = r_x;
    w_y_nx = r_y;
    w_z_nx = r_z;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (r_is_div) begin
        w_z_nx = {w_z_nx[WIDTH-1:0], w_y_nx[WIDTH-1]};
        w_y_nx = {w_y_nx[WIDTH-2:0], 1'b0};
        if (w_z_nx >= {1'b0, w_x_nx}) begin
          w_z_nx    = w_z_nx - {1'b0, w_x_nx};
          w_y_nx[0] = 1'b1;
        end else begin
          w_y_nx[0] = 1'b0;
        end
      end else begin
        if (w_y_nx[0]) w_z_nx = w_z_nx + {1'b0, w_x_nx};
        else           w_z_nx = w_z_nx;
        w_x_nx = {w_x_nx[WIDTH-2:0], 1'b0};
        w_y_nx = {1'b0, w_y_nx[WIDTH-1:1]};
      end
    end
  end

  // Iterative datapath: load on accept, step every RUN cycle (stall does not pause it)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= {WIDTH{1'b0}};
      r_y         <= {WIDTH{1'b0}};
      r_z         <= {(WIDTH+1){1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_is_div    <= 1'b0;
      r_pend_dr   <= 3'd0;
      r_pend_load <= 1'b0;
    end else if (w_fire && w_is_iter) begin
      r_x         <= (op_in == OP_DIV) ? b : a;
      r_y         <= (op_in == OP_DIV) ? a : b;
      r_z         <= {(WIDTH+1){1'b0}};
      r_cnt       <= CW'(N);
      r_is_div    <= (op_in == OP_DIV);
      r_pend_dr   <= dr_in;
      r_pend_load <= load_reg_in;
    end else if (r_state == S_RUN) begin
      r_x   <= w_x_nx;
      r_y   <= w_y_nx;
      r_z   <= w_z_nx;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {WIDTH{1'b0}};
      r_out_dr     <= 3'd0;
      r_out_load   <= 1'b0;
      r_out_dbz    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_dbz   <= 1'b0;
    end else if (mem_stall) begin
      r_out_valid <= r_out_valid;
    end else if (r_state == S_DONE) begin
      r_out_valid  <= 1'b1;
      r_out_result <= r_is_div ? r_y : r_z[WIDTH-1:0];
      r_out_dr     <= r_pend_dr;
      r_out_load   <= r_pend_load;
      r_out_dbz    <= 1'b0;
    end else if (w_fire && !w_is_iter) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_single;
      r_out_dr     <= dr_in;
      r_out_load   <= load_reg_in;
      r_out_dbz    <= w_div0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_dbz   <= 1'b0;
    end
  end

`ifdef EXECUTE_ITER_REM_EN
  logic [WIDTH-1:0] r_out_rem;

  // Remainder register, written alongside the result
  always_ff @(posedge clk) begin
    if (reset)                          r_out_rem <= {WIDTH{1'b0}};
    else if (flush || mem_stall)        r_out_rem <= r_out_rem;
    else if (r_state == S_DONE)         r_out_rem <= r_is_div ? r_z[WIDTH-1:0] : {WIDTH{1'b0}};
    else if (w_fire && !w_is_iter)      r_out_rem <= w_div0 ? a : {WIDTH{1'b0}};
    else                                r_out_rem <= r_out_rem;
  end

  assign out_rem = r_out_rem;
`endif

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_dr       = r_out_dr;
  assign out_load_reg = r_out_valid & r_out_load;
  assign div_by_zero  = r_out_dbz;
  assign out_cc       = r_out_result[WIDTH-1]                 ? 3'b100 :
                        (r_out_result == {WIDTH{1'b0}})       ? 3'b010 : 3'b001;

endmodule

// File: tb/tb_execute_iter.sv
// Scoreboard bench for execute_iter (WIDTH=16, BITS_PER_CYCLE=1); checks out_rem when EXECUTE_ITER_REM_EN is defined.
module tb_execute_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1, valid_in = 1'b0, load_reg_in = 1'b0, mem_stall = 1'b0, flush = 1'b0;
  logic [2:0]  op_in = 3'd0, dr_in = 3'd0;
  logic [15:0] a = 16'd0, b = 16'd0;
  logic        in_ready, out_valid, out_load_reg, div_by_zero;
  logic [15:0] out_result;
  logic [2:0]  out_dr, out_cc;
`ifdef EXECUTE_ITER_REM_EN
  logic [15:0] out_rem;
`endif

  execute_iter #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op_in(op_in), .a(a), .b(b),
    .dr_in(dr_in), .load_reg_in(load_reg_in), .mem_stall(mem_stall), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_result(out_result), .out_dr(out_dr),
    .out_load_reg(out_load_reg), .out_cc(out_cc), .div_by_zero(div_by_zero)
`ifdef EXECUTE_ITER_REM_EN
    , .out_rem(out_rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic [2:0]  dr;
    logic        ld;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_stall = 1'b0;

  function automatic logic [15:0] model_res(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    case (op)
      3'd0: return x + y;
      3'd1: return x & y;
      3'd2: return ~x;
      3'd3: return y;
      3'd4: return x << y[3:0];
      3'd5: return $unsigned($signed(x) >>> y[3:0]);
      3'd6: begin p = x * y; return p[15:0]; end
      default: return (y == 16'd0) ? 16'hFFFF : x / y;
    endcase
  endfunction

  function automatic logic [15:0] model_rem(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    if (op != 3'd7) return 16'd0;
    return (y == 16'd0) ? x : x % y;
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] r);
    return r[15] ? 3'b100 : (r == 16'd0) ? 3'b010 : 3'b001;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [2:0] dr, input logic ld, input logic expect_out);
    exp_t e;
    valid_in = 1'b1; op_in = op; a = x; b = y; dr_in = dr; load_reg_in = ld;
    if (expect_out) begin
      e.res = model_res(op, x, y); e.rem = model_rem(op, x, y);
      e.dr = dr; e.ld = ld; e.dbz = (op == 3'd7) && (y == 16'd0);
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: a new output is one that appeared on an edge without mem_stall
  always @(negedge clk) begin
    if (!reset && out_valid && !prev_stall) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: out_valid=1 result=%h with nothing queued", out_result);
      end else begin
        mon_e = sb.pop_front();
        if (out_result !== mon_e.res || out_dr !== mon_e.dr || out_load_reg !== mon_e.ld ||
            div_by_zero !== mon_e.dbz || out_cc !== cc_of(mon_e.res)) begin
          errors++;
          $display("FAIL scoreboard: got res=%h dr=%0d ld=%b dbz=%b cc=%b, expected res=%h dr=%0d ld=%b dbz=%b cc=%b",
                   out_result, out_dr, out_load_reg, div_by_zero, out_cc,
                   mon_e.res, mon_e.dr, mon_e.ld, mon_e.dbz, cc_of(mon_e.res));
        end
`ifdef EXECUTE_ITER_REM_EN
        checks++;
        if (out_rem !== mon_e.rem) begin
          errors++;
          $display("FAIL rem: got %h expected %h", out_rem, mon_e.rem);
        end
`endif
      end
    end
    prev_stall = mem_stall;
  end

  task automatic test_reset;
    reset = 1'b1; valid_in = 1'b1; op_in = 3'd0; a = 16'd5; b = 16'd5; flush = 1'b1;
    tick; tick;
    checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_result !== 16'd0)   begin errors++; $display("FAIL reset_result: got %h expected 0000", out_result); end
    checks++; if (out_dr !== 3'd0 || out_load_reg !== 1'b0 || div_by_zero !== 1'b0)
      begin errors++; $display("FAIL reset_regs: got dr=%0d ld=%b dbz=%b expected 0 0 0", out_dr, out_load_reg, div_by_zero); end
    checks++; if (out_cc !== 3'b010)      begin errors++; $display("FAIL reset_cc: got %b expected 010", out_cc); end
    checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    mem_stall = 1'b1; #1;
    checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    mem_stall = 1'b0; reset = 1'b0; valid_in = 1'b0; flush = 1'b0;
    tick;
  endtask

  task automatic test_add;
    drive(3'd0, 16'h7FFF, 16'h0001, 3'd3, 1'b1, 1'b1);
    tick;
    valid_in = 1'b0;
    checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if (out_result !== 16'h8000)  begin errors++; $display("FAIL add_result: got %h expected 8000", out_result); end
    checks++; if (out_cc !== 3'b100)        begin errors++; $display("FAIL add_cc: got %b expected 100", out_cc); end
    tick;
    checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL add_pulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  op;
    logic [15:0] x, y;
    for (int i = 0; i < 14; i++) begin
      op = (i == 13) ? 3'd7 : 3'(i % 6);
      x  = 16'($urandom);
      y  = (i == 13) ? 16'd0 : 16'($urandom);
      if (i == 12) begin x = 16'h8421; y = 16'h0004; op = 3'd5; end
      drive(op, x, y, 3'(i % 8), i[0], 1'b1);
      tick;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
    end
    valid_in = 1'b0;
    tick;
  endtask

  task automatic run_iter(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y, input logic [2:0] dr);
    int low, vcnt, vcyc;
    drive(op, x, y, dr, 1'b1, 1'b1);
    tick;
    valid_in = 1'b0;
    low = in_ready ? 0 : 1; vcnt = 0; vcyc = -1;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (!in_ready) low++;
      if (out_valid) begin vcnt++; if (vcyc < 0) vcyc = c; end
    end
    checks++; if (low != 17)  begin errors++; $display("FAIL iter_ready_low op%0d: got %0d cycles expected 17", op, low); end
    checks++; if (vcyc != 17) begin errors++; $display("FAIL iter_latency op%0d: got %0d expected 17", op, vcyc); end
    checks++; if (vcnt != 1)  begin errors++; $display("FAIL iter_pulse op%0d: got %0d valid cycles expected 1", op, vcnt); end
  endtask

  task automatic test_mul;
    run_iter(3'd6, 16'h0003, 16'h0005, 3'd1);
    run_iter(3'd6, 16'hFFFF, 16'hFFFF, 3'd2);
    run_iter(3'd6, 16'h1234, 16'h0010, 3'd4);
  endtask

  task automatic test_div;
    run_iter(3'd7, 16'h0064, 16'h0007, 3'd5);
    run_iter(3'd7, 16'hFFFF, 16'h0001, 3'd6);
    run_iter(3'd7, 16'h0005, 16'h0009, 3'd7);
    run_iter(3'd7, 16'hFFFE, 16'h8001, 3'd0);
  endtask

  task automatic test_div0;
    drive(3'd7, 16'h1234, 16'h0000, 3'd2, 1'b1, 1'b1);
    tick;
    valid_in = 1'b0;
    checks++; if (out_valid !== 1'b1 || div_by_zero !== 1'b1)
      begin errors++; $display("FAIL div0_flags: got valid=%b dbz=%b expected 1 1", out_valid, div_by_zero); end
    checks++; if (out_result !== 16'hFFFF) begin errors++; $display("FAIL div0_result: got %h expected FFFF", out_result); end
    checks++; if (in_ready !== 1'b1)       begin errors++; $display("FAIL div0_no_run: in_ready got %b expected 1", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0 || div_by_zero !== 1'b0)
      begin errors++; $display("FAIL div0_clear: got valid=%b dbz=%b expected 0 0", out_valid, div_by_zero); end
  endtask

  task automatic test_mul_stall;
    int vcnt, vcyc, held_bad;
    drive(3'd0, 16'h0010, 16'h0020, 3'd1, 1'b1, 1'b1);
    tick;
    drive(3'd6, 16'h0003, 16'h0005, 3'd3, 1'b0, 1'b1);
    tick;
    valid_in = 1'b0;
    vcnt = 0; vcyc = -1; held_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (out_valid) begin vcnt++; if (vcyc < 0) vcyc = c; end
      if (c <= 25 && out_result !== 16'h0030) held_bad++;
      mem_stall = (c >= 9 && c < 25);
    end
    checks++; if (vcyc != 26)    begin errors++; $display("FAIL stall_latency: got %0d expected 26", vcyc); end
    checks++; if (vcnt != 1)     begin errors++; $display("FAIL stall_pulse: got %0d expected 1", vcnt); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d changed cycles expected 0", held_bad); end
  endtask

  task automatic test_flush_reset;
    int vseen;
    vseen = 0;
    drive(3'd6, 16'h0003, 16'h0005, 3'd1, 1'b1, 1'b0);
    tick; valid_in = 1'b0;
    for (int c = 1; c <= 4; c++) begin tick; if (out_valid) vseen++; end
    flush = 1'b1; tick; flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_run: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid); end
    drive(3'd6, 16'h0007, 16'h0009, 3'd2, 1'b1, 1'b0);
    tick; valid_in = 1'b0;
    for (int c = 1; c <= 7; c++) begin tick; if (out_valid) vseen++; end
    reset = 1'b1; tick; reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_run: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid); end
    for (int c = 0; c < 20; c++) begin tick; if (out_valid) vseen++; end
    drive(3'd0, 16'h0001, 16'h0002, 3'd3, 1'b1, 1'b0);
    flush = 1'b1; tick; flush = 1'b0; valid_in = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_vs_valid: got %b expected 0", out_valid); end
    drive(3'd6, 16'h0002, 16'h0002, 3'd4, 1'b1, 1'b0);
    tick; valid_in = 1'b0;
    for (int c = 1; c <= 16; c++) begin tick; if (out_valid) vseen++; end
    flush = 1'b1; tick; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin tick; if (out_valid) vseen++; end
    checks++; if (vseen != 0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_done: got %0d valid cycles in_ready=%b expected 0 1", vseen, in_ready); end
    drive(3'd0, 16'h1111, 16'h2222, 3'd5, 1'b1, 1'b1);
    tick; valid_in = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 16'h3333)
      begin errors++; $display("FAIL post_flush_add: got valid=%b res=%h expected 1 3333", out_valid, out_result); end
    tick;
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_mul;
    test_div;
    test_div0;
    test_mul_stall;
    test_flush_reset;
    repeat (3) tick;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
